aes_req_sched: RTL

//  Round-robin scheduler sharing one encrypt_aes core among NUM_REQ requesters.

---
 rtl/aes_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/aes_req_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES request scheduler: FSM state encoding,
// AES operand widths and key-type codes.
package aes_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } sched_state_e;

    localparam int AES_BLK_W = 128;
    localparam int AES_KEY_W = 256;

    localparam logic AES_TYPE_128 = 1'b0;
    localparam logic AES_TYPE_256 = 1'b1;

endpackage : aes_sched_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps at
// NUM_REQ; the first asserted request wins. The pointer register is kept by
// the caller so this block stays purely combinational.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    id
);

    logic [ID_W:0]   pos;
    logic [ID_W-1:0] idx;
    logic            found;

    // Rotating priority search: first valid request at or after ptr wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        pos   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, ptr} + (ID_W+1)'(i);
            if (pos >= (ID_W+1)'(NUM_REQ)) begin
                pos = pos - (ID_W+1)'(NUM_REQ);
            end
            idx = pos[ID_W-1:0];
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                id       = idx;
                found    = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/aes_req_sched.sv
// Round-robin scheduler sharing one encrypt_aes core among NUM_REQ requesters.
// A grant latches the winner's block/key/type, holds core_enable high for
// HOLD_CYCLES, releases the core, waits for a fresh done, and returns the
// ciphertext tagged with the requester id on a valid/ready channel.
// Optional RUN watchdog: define AES_SCHED_TIMEOUT_EN to enable it; otherwise
// RUN waits indefinitely and resp_err is tied low.
module aes_req_sched
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int HOLD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*AES_BLK_W-1:0] req_data,
    input  logic [NUM_REQ*AES_KEY_W-1:0] req_key,
    input  logic [NUM_REQ-1:0]           req_type,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [ID_W-1:0]              resp_id,
    output logic [AES_BLK_W-1:0]         resp_data,
    output logic                         resp_err,
    output logic [AES_BLK_W-1:0]         core_in,
    output logic [AES_KEY_W-1:0]         core_key,
    output logic                         core_type,
    output logic                         core_enable,
    input  logic                         core_done,
    input  logic [AES_BLK_W-1:0]         core_out,
    output logic                         busy
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_RESP = RESP;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [1:0]           state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      next_ptr;
    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_id;
    logic                 grant_fire;
    logic [AES_BLK_W-1:0] sel_data;
    logic [AES_KEY_W-1:0] sel_key;
    logic                 sel_type;
    logic [HOLD_W-1:0]    hold_cnt;
    logic                 hold_done;
    logic                 armed;
    logic                 timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .en  (state == ST_IDLE),
        .gnt (gnt),
        .id  (gnt_id)
    );

    assign req_ready  = gnt;
    assign grant_fire = |gnt;
    assign busy       = (state != ST_IDLE);
    assign hold_done  = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    assign next_ptr   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

    // Operand mux: select the granted requester's slices.
    always_comb begin
        sel_data = '0;
        sel_key  = '0;
        sel_type = AES_TYPE_128;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_data = req_data[i*AES_BLK_W +: AES_BLK_W];
                sel_key  = req_key[i*AES_KEY_W +: AES_KEY_W];
                sel_type = req_type[i];
            end
        end
    end

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int RUN_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [RUN_W-1:0] run_cnt;
    logic             resp_err_q;

    assign timeout_hit = (state == ST_RUN) && (run_cnt == RUN_W'(TIMEOUT_CYCLES - 1));
    assign resp_err    = resp_err_q;

    // RUN watchdog: count cycles spent in RUN, cleared while loading.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt <= '0;
        end else if (state == ST_LOAD) begin
            run_cnt <= '0;
        end else if (state == ST_RUN) begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end

    // Error flag: set on a watchdog abort, cleared by the response handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_err_q <= 1'b0;
        end else if (timeout_hit && !(armed && core_done)) begin
            resp_err_q <= 1'b1;
        end else if (state == ST_RESP && resp_ready) begin
            resp_err_q <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
`endif

    // Job sequencer: grant, hold core in start, run, return the response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            armed       <= 1'b0;
            core_in     <= '0;
            core_key    <= '0;
            core_type   <= AES_TYPE_128;
            core_enable <= 1'b1;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_data   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (grant_fire) begin
                        core_in   <= sel_data;
                        core_key  <= sel_key;
                        core_type <= sel_type;
                        resp_id   <= gnt_id;
                        rr_ptr    <= next_ptr;
                        hold_cnt  <= '0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (hold_done) begin
                        core_enable <= 1'b0;
                        armed       <= 1'b0;
                        state       <= ST_RUN;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    // A done level is trusted only after the core was seen busy.
                    if (!core_done) begin
                        armed <= 1'b1;
                    end
                    if (armed && core_done) begin
                        resp_data  <= core_out;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else if (timeout_hit) begin
                        resp_data   <= '0;
                        resp_valid  <= 1'b1;
                        core_enable <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid  <= 1'b0;
                        core_enable <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : aes_req_sched
